phase_sequencer: RTL and testbench

//  Parametrised instruction-cycle phase generator; successor to the fixed 4-output clock_divisor.

---
 rtl/phase_sequencer_if.sv | 32 +++
 rtl/phase_sequencer.sv | 148 ++++++++++++++
 tb/tb_phase_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Control and status bundle for the instruction-cycle phase sequencer.
// The master side (instruction controller) drives run/stall/flush; the
// slave side (the sequencer) returns the phase enables and cycle status.
interface phase_sequencer_if #(
    parameter int NUM_PHASES = 4,
    parameter int CYC_CNT_W  = 16
);
    localparam int PIDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic                  run;
    logic                  stall;
    logic                  flush;
    logic [NUM_PHASES-1:0] phase_en;
    logic [PIDX_W-1:0]     phase_idx;
    logic                  cycle_start;
    logic                  cycle_end;
    logic                  flush_cycle;
    logic [CYC_CNT_W-1:0]  cycle_count;
    logic                  busy;

    modport master (
        output run, stall, flush,
        input  phase_en, phase_idx, cycle_start, cycle_end,
        input  flush_cycle, cycle_count, busy
    );

    modport slave (
        input  run, stall, flush,
        output phase_en, phase_idx, cycle_start, cycle_end,
        output flush_cycle, cycle_count, busy
    );
endinterface

// File: rtl/phase_sequencer.sv
// Instruction-cycle phase generator: one-hot phase enables on a single clock,
// with prescaling, stall between cycles, flush (bubble) cycle insertion and a
// retired-cycle counter. All outputs are decodes of registered state only.
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int PRESCALE   = 1,
    parameter int CYC_CNT_W  = 16
) (
    input  logic               master_clk,
    input  logic               reset,
    phase_sequencer_if.slave   bus
);
    localparam int PIDX_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PIDX_W-1:0]  LAST_PHASE = PIDX_W'(NUM_PHASES - 1);
    localparam logic [PRESC_W-1:0] LAST_PRESC = PRESC_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t                 state_r,       state_nx_s;
    logic [PRESC_W-1:0]     presc_r,       presc_nx_s;
    logic [PIDX_W-1:0]      phase_idx_r,   phase_idx_nx_s;
    logic                   flush_pend_r,  flush_pend_nx_s;
    logic                   flush_cycle_r, flush_cycle_nx_s;
    logic [CYC_CNT_W-1:0]   cycle_count_r, cycle_count_nx_s;
    logic [NUM_PHASES-1:0]  phase_en_s;

    // State register: synchronous reset aborts any cycle and drops pending flush
    always_ff @(posedge master_clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            presc_r       <= '0;
            phase_idx_r   <= '0;
            flush_pend_r  <= 1'b0;
            flush_cycle_r <= 1'b0;
            cycle_count_r <= '0;
        end else begin
            state_r       <= state_nx_s;
            presc_r       <= presc_nx_s;
            phase_idx_r   <= phase_idx_nx_s;
            flush_pend_r  <= flush_pend_nx_s;
            flush_cycle_r <= flush_cycle_nx_s;
            cycle_count_r <= cycle_count_nx_s;
        end
    end

    // Next-state logic: prescaler, phase advance, boundary decisions, flush arming
    always_comb begin
        state_nx_s       = state_r;
        presc_nx_s       = presc_r;
        phase_idx_nx_s   = phase_idx_r;
        flush_pend_nx_s  = flush_pend_r;
        flush_cycle_nx_s = flush_cycle_r;
        cycle_count_nx_s = cycle_count_r;
        case (state_r)
            ST_IDLE: begin
                // flush is ignored here; a fresh run always starts with a normal cycle
                presc_nx_s       = '0;
                phase_idx_nx_s   = '0;
                flush_pend_nx_s  = 1'b0;
                flush_cycle_nx_s = 1'b0;
                if (bus.run) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (presc_r != LAST_PRESC) begin
                    presc_nx_s      = presc_r + PRESC_W'(1);
                    flush_pend_nx_s = flush_pend_r | bus.flush;
                end else if (phase_idx_r != LAST_PHASE) begin
                    presc_nx_s      = '0;
                    phase_idx_nx_s  = phase_idx_r + PIDX_W'(1);
                    flush_pend_nx_s = flush_pend_r | bus.flush;
                end else begin
                    // cycle boundary: retire the cycle, then run > stall > continue
                    presc_nx_s       = '0;
                    phase_idx_nx_s   = '0;
                    cycle_count_nx_s = cycle_count_r + CYC_CNT_W'(1);
                    if (!bus.run) begin
                        state_nx_s       = ST_IDLE;
                        flush_pend_nx_s  = 1'b0;
                        flush_cycle_nx_s = 1'b0;
                    end else if (bus.stall) begin
                        state_nx_s       = ST_STALL;
                        flush_pend_nx_s  = flush_pend_r | bus.flush;
                        flush_cycle_nx_s = 1'b0;
                    end else begin
                        state_nx_s       = ST_RUN;
                        flush_pend_nx_s  = 1'b0;
                        flush_cycle_nx_s = flush_pend_r | bus.flush;
                    end
                end
            end
            ST_STALL: begin
                presc_nx_s       = '0;
                phase_idx_nx_s   = '0;
                flush_cycle_nx_s = 1'b0;
                if (!bus.run) begin
                    state_nx_s      = ST_IDLE;
                    flush_pend_nx_s = 1'b0;
                end else if (!bus.stall) begin
                    // a flush held through the stall becomes the resumed cycle
                    state_nx_s       = ST_RUN;
                    flush_pend_nx_s  = 1'b0;
                    flush_cycle_nx_s = flush_pend_r | bus.flush;
                end else begin
                    state_nx_s      = ST_STALL;
                    flush_pend_nx_s = flush_pend_r | bus.flush;
                end
            end
            default: begin
                state_nx_s       = ST_IDLE;
                presc_nx_s       = '0;
                phase_idx_nx_s   = '0;
                flush_pend_nx_s  = 1'b0;
                flush_cycle_nx_s = 1'b0;
            end
        endcase
    end

    // Output decode: enables pulse on the last clock of each phase, only while running
    always_comb begin
        phase_en_s    = '0;
        bus.phase_idx = '0;
        if (state_r == ST_RUN) begin
            bus.phase_idx = phase_idx_r;
            if (presc_r == LAST_PRESC) begin
                phase_en_s = NUM_PHASES'(1) << phase_idx_r;
            end else begin
                phase_en_s = '0;
            end
        end else begin
            bus.phase_idx = '0;
        end
        bus.phase_en    = phase_en_s;
        bus.cycle_start = phase_en_s[0];
        bus.cycle_end   = phase_en_s[NUM_PHASES-1];
        bus.flush_cycle = flush_cycle_r;
        bus.cycle_count = cycle_count_r;
        bus.busy        = (state_r == ST_RUN) || (state_r == ST_STALL);
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench: two sequencer configurations driven by identical
// stimulus, each compared every clock against a timeline-based reference
// model (one clock counter per instruction cycle, phases derived by division).
module tb_phase_sequencer;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STALL = 2;

    logic master_clk = 1'b0;
    logic reset = 1'b1;
    logic r_run = 1'b0, r_stall = 1'b0, r_flush = 1'b0;

    int checks = 0;
    int errors = 0;

    // configuration of each DUT: phases, prescale, counter modulus
    int np   [2] = '{4, 5};
    int ps   [2] = '{1, 3};
    int cmod [2] = '{16, 65536};

    // reference model state
    int mode [2] = '{M_IDLE, M_IDLE};
    int tpos [2] = '{0, 0};
    int pend [2] = '{0, 0};
    int fcyc [2] = '{0, 0};
    int cnt  [2] = '{0, 0};

    phase_sequencer_if #(.NUM_PHASES(4), .CYC_CNT_W(4))  bus_a ();
    phase_sequencer_if #(.NUM_PHASES(5), .CYC_CNT_W(16)) bus_b ();

    phase_sequencer #(.NUM_PHASES(4), .PRESCALE(1), .CYC_CNT_W(4)) dut_a (
        .master_clk (master_clk),
        .reset      (reset),
        .bus        (bus_a.slave)
    );

    phase_sequencer #(.NUM_PHASES(5), .PRESCALE(3), .CYC_CNT_W(16)) dut_b (
        .master_clk (master_clk),
        .reset      (reset),
        .bus        (bus_b.slave)
    );

    always #5 master_clk = ~master_clk;

    task automatic model_step(input int k);
        int len;
        len = np[k] * ps[k];
        if (reset) begin
            mode[k] = M_IDLE; tpos[k] = 0; pend[k] = 0; fcyc[k] = 0; cnt[k] = 0;
        end else if (mode[k] == M_IDLE) begin
            pend[k] = 0; fcyc[k] = 0; tpos[k] = 0;
            if (r_run) mode[k] = M_RUN;
        end else if (mode[k] == M_RUN) begin
            if (tpos[k] == len - 1) begin
                cnt[k]  = (cnt[k] + 1) % cmod[k];
                tpos[k] = 0;
                if (!r_run) begin
                    mode[k] = M_IDLE; pend[k] = 0; fcyc[k] = 0;
                end else if (r_stall) begin
                    mode[k] = M_STALL; fcyc[k] = 0; pend[k] = pend[k] | int'(r_flush);
                end else begin
                    fcyc[k] = pend[k] | int'(r_flush); pend[k] = 0;
                end
            end else begin
                tpos[k] = tpos[k] + 1;
                pend[k] = pend[k] | int'(r_flush);
            end
        end else begin
            if (!r_run) begin
                mode[k] = M_IDLE; pend[k] = 0;
            end else if (!r_stall) begin
                mode[k] = M_RUN; tpos[k] = 0; fcyc[k] = pend[k] | int'(r_flush); pend[k] = 0;
            end else begin
                pend[k] = pend[k] | int'(r_flush);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_dut(input int k, input string nm, input logic [31:0] pe, input logic [31:0] pidx,
                           input logic [31:0] cs, input logic [31:0] ce, input logic [31:0] fc,
                           input logic [31:0] cc, input logic [31:0] bsy);
        int e_pe, e_pidx, e_run;
        e_run  = (mode[k] == M_RUN) ? 1 : 0;
        e_pidx = e_run ? tpos[k] / ps[k] : 0;
        e_pe   = (e_run && (tpos[k] % ps[k] == ps[k] - 1)) ? (1 << (tpos[k] / ps[k])) : 0;
        chk({nm, ".phase_en"},    pe,   e_pe);
        chk({nm, ".phase_idx"},   pidx, e_pidx);
        chk({nm, ".cycle_start"}, cs,   e_pe & 1);
        chk({nm, ".cycle_end"},   ce,   (e_pe >> (np[k] - 1)) & 1);
        chk({nm, ".flush_cycle"}, fc,   e_run ? fcyc[k] : 0);
        chk({nm, ".cycle_count"}, cc,   cnt[k]);
        chk({nm, ".busy"},        bsy,  (mode[k] != M_IDLE) ? 1 : 0);
    endtask

    // one clock: drive at negedge, model at posedge, compare at the following negedge
    task automatic step(input logic rs, input logic ru, input logic st, input logic fl);
        reset = rs; r_run = ru; r_stall = st; r_flush = fl;
        bus_a.run = ru; bus_a.stall = st; bus_a.flush = fl;
        bus_b.run = ru; bus_b.stall = st; bus_b.flush = fl;
        @(posedge master_clk);
        model_step(0);
        model_step(1);
        @(negedge master_clk);
        chk_dut(0, "A", 32'(bus_a.phase_en), 32'(bus_a.phase_idx), 32'(bus_a.cycle_start),
                32'(bus_a.cycle_end), 32'(bus_a.flush_cycle), 32'(bus_a.cycle_count), 32'(bus_a.busy));
        chk_dut(1, "B", 32'(bus_b.phase_en), 32'(bus_b.phase_idx), 32'(bus_b.cycle_start),
                32'(bus_b.cycle_end), 32'(bus_b.flush_cycle), 32'(bus_b.cycle_count), 32'(bus_b.busy));
    endtask

    task automatic repeat_step(input int n, input logic rs, input logic ru, input logic st, input logic fl);
        for (int i = 0; i < n; i++) step(rs, ru, st, fl);
    endtask

    initial begin
        @(negedge master_clk);
        // reset state
        repeat_step(2, 1'b1, 1'b0, 1'b0, 1'b0);
        // flush while idle must be ignored
        repeat_step(2, 1'b0, 1'b0, 1'b0, 1'b1);
        // free run: phase rotation and count
        repeat_step(33, 1'b0, 1'b1, 1'b0, 1'b0);
        // stall held across boundaries, then release
        repeat_step(17, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat_step(6, 1'b0, 1'b1, 1'b0, 1'b0);
        // single flush pulse mid-cycle, then several pulses collapsing
        step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat_step(12, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat_step(3, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat_step(20, 1'b0, 1'b1, 1'b0, 1'b0);
        // flush together with stall: stall first, flush cycle on resume
        repeat_step(16, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat_step(20, 1'b0, 1'b1, 1'b0, 1'b0);
        // continuous flush: back-to-back flush cycles
        repeat_step(30, 1'b0, 1'b1, 1'b0, 1'b1);
        // long run so the narrow counter wraps
        repeat_step(80, 1'b0, 1'b1, 1'b0, 1'b0);
        // run dropped mid-cycle: the cycle finishes, then idle
        repeat_step(18, 1'b0, 1'b0, 1'b0, 1'b0);
        // reset mid-cycle with a pending flush and run held high
        repeat_step(7, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat_step(20, 1'b0, 1'b1, 1'b0, 1'b0);
        // randomized mix
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
